// File: rtl/sdram_arbit_if.sv
// Client/pin bundle for the SDRAM command-bus arbiter.
// Pure wiring: no state, no latency.
// Clients hold their request until they see their grant; grant drops the cycle after end.
interface sdram_arbit_if;
  // init sequencer
  logic        init_end;
  logic [3:0]  init_cmd;
  logic [12:0] init_addr;
  // auto-refresh sequencer
  logic        ref_req;
  logic        ref_end;
  logic [3:0]  ref_cmd;
  logic [12:0] ref_addr;
  // write sequencer
  logic        wr_req;
  logic        wr_end;
  logic [3:0]  wr_cmd;
  logic [12:0] wr_addr;
  logic [1:0]  wr_bank;
  // read sequencer
  logic        rd_req;
  logic        rd_end;
  logic [3:0]  rd_cmd;
  logic [12:0] rd_addr;
  logic [1:0]  rd_bank;
  // grants
  logic        ref_en;
  logic        wr_en;
  logic        rd_en;
  // SDRAM pins
  logic        sdram_cke;
  logic [3:0]  sdram_cmd;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba;

  // arbiter side: consumes client requests, drives grants and pins
  modport master (
    input  init_end, init_cmd, init_addr,
    input  ref_req, ref_end, ref_cmd, ref_addr,
    input  wr_req, wr_end, wr_cmd, wr_addr, wr_bank,
    input  rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    output ref_en, wr_en, rd_en,
    output sdram_cke, sdram_cmd, sdram_addr, sdram_ba
  );

  // client side: drives requests and commands, observes grants and pins
  modport slave (
    output init_end, init_cmd, init_addr,
    output ref_req, ref_end, ref_cmd, ref_addr,
    output wr_req, wr_end, wr_cmd, wr_addr, wr_bank,
    output rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    input  ref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cmd, sdram_addr, sdram_ba
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: one grant at a time among init/refresh/write/read, muxes the owner onto the pins.
// Latency: request seen in ARBIT at cycle n -> grant at n+1; grant drops the cycle after end or watchdog expiry.
// Backpressure: requests wait (held by client) while another client owns the bus; optional SDRAM_ARB_RR_EN alternates write/read.
module sdram_arbit #(
  parameter int TMO_W = 11
) (
  input  logic          i_sclk,
  input  logic          i_reset,
  sdram_arbit_if.master bus,
  output logic          o_err_tmo
);

  typedef enum logic [4:0] {
    S_INIT  = 5'b00001,
    S_ARBIT = 5'b00010,
    S_AREF  = 5'b00100,
    S_WRITE = 5'b01000,
    S_READ  = 5'b10000
  } state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_nxt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err_tmo;
  logic             r_cke;
  logic             w_tmo_hit;
  logic             w_in_grant;
  logic             w_cnt_max;

`ifdef SDRAM_ARB_RR_EN
  logic             r_last_wr;
`endif

  assign w_in_grant = (r_state == S_AREF) || (r_state == S_WRITE) || (r_state == S_READ);
  assign w_cnt_max  = (r_tmo_cnt == TMO_MAX);

  // state register
  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_nxt;
    end
  end

  // next-state decode: fixed priority ref > wr > rd, own end or watchdog releases the bus
  always_comb begin
    w_nxt     = r_state;
    w_tmo_hit = 1'b0;
    case (r_state)
      S_INIT: begin
        if (bus.init_end) w_nxt = S_ARBIT;
      end
      S_ARBIT: begin
        // end pulses arriving here are stale and deliberately ignored
        if (bus.ref_req) begin
          w_nxt = S_AREF;
`ifdef SDRAM_ARB_RR_EN
        end else if (bus.wr_req && bus.rd_req) begin
          // contention between write and read: serve the one that waited last time
          w_nxt = r_last_wr ? S_READ : S_WRITE;
`endif
        end else if (bus.wr_req) begin
          w_nxt = S_WRITE;
        end else if (bus.rd_req) begin
          w_nxt = S_READ;
        end
      end
      S_AREF: begin
        if (bus.ref_end) begin
          w_nxt = S_ARBIT;
        end else if (w_cnt_max) begin
          w_nxt     = S_ARBIT;
          w_tmo_hit = 1'b1;
        end
      end
      S_WRITE: begin
        if (bus.wr_end) begin
          w_nxt = S_ARBIT;
        end else if (w_cnt_max) begin
          w_nxt     = S_ARBIT;
          w_tmo_hit = 1'b1;
        end
      end
      S_READ: begin
        if (bus.rd_end) begin
          w_nxt = S_ARBIT;
        end else if (w_cnt_max) begin
          w_nxt     = S_ARBIT;
          w_tmo_hit = 1'b1;
        end
      end
      default: begin
        // any non-one-hot value restarts from init so the pins are never driven ambiguously
        w_nxt = S_INIT;
      end
    endcase
  end

  // grant watchdog: counts while a client holds the bus, cleared whenever it leaves
  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      r_tmo_cnt <= '0;
    end else if (w_in_grant && (w_nxt == r_state)) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  // timeout flag: single-cycle pulse coinciding with the return to ARBIT
  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      r_err_tmo <= 1'b0;
    end else begin
      r_err_tmo <= w_tmo_hit;
    end
  end

  // clock enable is held high; registered so the pin comes straight from a flop
  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      r_cke <= 1'b1;
    end else begin
      r_cke <= 1'b1;
    end
  end

`ifdef SDRAM_ARB_RR_EN
  // remember which of write/read was served last, updated only on a new grant
  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      r_last_wr <= 1'b0;
    end else if (r_state == S_ARBIT) begin
      if (w_nxt == S_WRITE) begin
        r_last_wr <= 1'b1;
      end else if (w_nxt == S_READ) begin
        r_last_wr <= 1'b0;
      end
    end
  end
`endif

  // output decode: grants and pin mux straight from the registered one-hot state
  always_comb begin
    bus.ref_en     = 1'b0;
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.sdram_cmd  = CMD_NOP;
    bus.sdram_addr = 13'd0;
    bus.sdram_ba   = 2'd0;
    case (r_state)
      S_INIT: begin
        bus.sdram_cmd  = bus.init_cmd;
        bus.sdram_addr = bus.init_addr;
      end
      S_AREF: begin
        bus.ref_en     = 1'b1;
        bus.sdram_cmd  = bus.ref_cmd;
        bus.sdram_addr = bus.ref_addr;
      end
      S_WRITE: begin
        bus.wr_en      = 1'b1;
        bus.sdram_cmd  = bus.wr_cmd;
        bus.sdram_addr = bus.wr_addr;
        bus.sdram_ba   = bus.wr_bank;
      end
      S_READ: begin
        bus.rd_en      = 1'b1;
        bus.sdram_cmd  = bus.rd_cmd;
        bus.sdram_addr = bus.rd_addr;
        bus.sdram_ba   = bus.rd_bank;
      end
      default: begin
        bus.sdram_cmd  = CMD_NOP;
      end
    endcase
  end

  assign bus.sdram_cke = r_cke;
  assign o_err_tmo     = r_err_tmo;

endmodule

// File: tb/tb_sdram_arbit.sv
// Testbench for sdram_arbit: table of request patterns with a scoreboard of expected grants/pins,
// plus hand sequences for init, ref/wr ordering, read mux, write/read alternation, watchdog and reset.
// Build with +define+SDRAM_ARB_RR_EN to check the alternating write/read variant.
module tb_sdram_arbit;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_REF  = 2'd1;
  localparam logic [1:0] G_WR   = 2'd2;
  localparam logic [1:0] G_RD   = 2'd3;

  localparam logic [3:0]  INIT_CMD  = 4'b0010;
  localparam logic [12:0] INIT_ADDR = 13'h0A37;
  localparam logic [3:0]  REF_CMD   = 4'b0001;
  localparam logic [12:0] REF_ADDR  = 13'h0400;
  localparam logic [3:0]  WR_CMD    = 4'b0100;
  localparam logic [12:0] WR_ADDR   = 13'h1234;
  localparam logic [1:0]  WR_BANK   = 2'd2;
  localparam logic [3:0]  RD_CMD    = 4'b0101;
  localparam logic [12:0] RD_ADDR   = 13'h0ABC;
  localparam logic [1:0]  RD_BANK   = 2'd1;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
  } exp_t;

  typedef struct {
    logic       ref_r;
    logic       wr_r;
    logic       rd_r;
    logic [1:0] gnt;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic err_tmo;

  sdram_arbit_if bus();

  sdram_arbit #(.TMO_W(11)) dut (
    .i_sclk    (clk),
    .i_reset   (rst),
    .bus       (bus),
    .o_err_tmo (err_tmo)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic exp_t mk(input logic [1:0] g);
    exp_t e;
    case (g)
      G_REF:   e = '{gnt: g, cmd: REF_CMD, addr: REF_ADDR, ba: 2'd0};
      G_WR:    e = '{gnt: g, cmd: WR_CMD,  addr: WR_ADDR,  ba: WR_BANK};
      G_RD:    e = '{gnt: g, cmd: RD_CMD,  addr: RD_ADDR,  ba: RD_BANK};
      default: e = '{gnt: g, cmd: 4'b0111, addr: 13'd0,    ba: 2'd0};
    endcase
    return e;
  endfunction

  function automatic logic [2:0] en_of(input logic [1:0] g);
    case (g)
      G_REF:   return 3'b100;
      G_WR:    return 3'b010;
      G_RD:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] gnt_now();
    if (bus.ref_en) return G_REF;
    if (bus.wr_en)  return G_WR;
    if (bus.rd_en)  return G_RD;
    return G_NONE;
  endfunction

  task automatic check_out(input string name, input exp_t e);
    chk({name, "_en"},   {29'd0, bus.ref_en, bus.wr_en, bus.rd_en}, {29'd0, en_of(e.gnt)});
    chk({name, "_cmd"},  {28'd0, bus.sdram_cmd},  {28'd0, e.cmd});
    chk({name, "_addr"}, {19'd0, bus.sdram_addr}, {19'd0, e.addr});
    chk({name, "_ba"},   {30'd0, bus.sdram_ba},   {30'd0, e.ba});
  endtask

  task automatic set_end(input logic [1:0] g, input logic v);
    case (g)
      G_REF:   bus.ref_end = v;
      G_WR:    bus.wr_end  = v;
      G_RD:    bus.rd_end  = v;
      default: ;
    endcase
  endtask

  task automatic set_req(input logic r, input logic w, input logic d);
    bus.ref_req = r;
    bus.wr_req  = w;
    bus.rd_req  = d;
  endtask

  initial begin
    vec_t v;
    exp_t e;
    logic [1:0] g;
    logic [1:0] fg;
    int n;
    logic [1:0] rr_exp [4];
`ifdef SDRAM_ARB_RR_EN
    logic last_wr;
    last_wr = 1'b0;
    rr_exp[0] = G_WR; rr_exp[1] = G_RD; rr_exp[2] = G_WR; rr_exp[3] = G_RD;
`else
    rr_exp[0] = G_WR; rr_exp[1] = G_WR; rr_exp[2] = G_WR; rr_exp[3] = G_WR;
`endif

    vecs[0] = '{1'b1, 1'b0, 1'b0, G_REF,  "ref"};
    vecs[1] = '{1'b0, 1'b1, 1'b0, G_WR,   "wr"};
    vecs[2] = '{1'b0, 1'b0, 1'b1, G_RD,   "rd"};
    vecs[3] = '{1'b1, 1'b1, 1'b0, G_REF,  "ref_wr"};
    vecs[4] = '{1'b0, 1'b1, 1'b1, G_WR,   "wr_rd_a"};
    vecs[5] = '{1'b0, 1'b1, 1'b1, G_WR,   "wr_rd_b"};
    vecs[6] = '{1'b1, 1'b1, 1'b1, G_REF,  "all"};
    vecs[7] = '{1'b1, 1'b0, 1'b1, G_REF,  "ref_rd"};
    vecs[8] = '{1'b0, 1'b0, 1'b0, G_NONE, "idle"};

    rst           = 1'b1;
    bus.init_end  = 1'b0;
    bus.init_cmd  = INIT_CMD;
    bus.init_addr = INIT_ADDR;
    bus.ref_end   = 1'b0;
    bus.ref_cmd   = REF_CMD;
    bus.ref_addr  = REF_ADDR;
    bus.wr_end    = 1'b0;
    bus.wr_cmd    = WR_CMD;
    bus.wr_addr   = WR_ADDR;
    bus.wr_bank   = WR_BANK;
    bus.rd_end    = 1'b0;
    bus.rd_cmd    = RD_CMD;
    bus.rd_addr   = RD_ADDR;
    bus.rd_bank   = RD_BANK;
    set_req(1'b0, 1'b0, 1'b0);

    // reset state
    step();
    step();
    chk("rst_en",   {29'd0, bus.ref_en, bus.wr_en, bus.rd_en}, 32'd0);
    chk("rst_cmd",  {28'd0, bus.sdram_cmd},  {28'd0, INIT_CMD});
    chk("rst_addr", {19'd0, bus.sdram_addr}, {19'd0, INIT_ADDR});
    chk("rst_ba",   {30'd0, bus.sdram_ba},   32'd0);
    chk("rst_cke",  {31'd0, bus.sdram_cke},  32'd1);
    chk("rst_err",  {31'd0, err_tmo},        32'd0);
    rst = 1'b0;

    // init: stays in S_INIT through cycle 10, init_end at cycle 10 -> ARBIT at 11
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 10) chk("init_c10_cmd", {28'd0, bus.sdram_cmd}, {28'd0, INIT_CMD});
    end
    bus.init_end = 1'b1;
    step();
    bus.init_end = 1'b0;
    check_out("init_c11", mk(G_NONE));

    // init_end again while arbitrating is ignored
    bus.init_end = 1'b1;
    step();
    bus.init_end = 1'b0;
    step();
    check_out("init_again", mk(G_NONE));

    // table: one-cycle request pattern in ARBIT, grant next cycle, foreign end ignored, own end releases
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      g = v.gnt;
`ifdef SDRAM_ARB_RR_EN
      if (!v.ref_r && v.wr_r && v.rd_r) g = last_wr ? G_RD : G_WR;
`endif
      set_req(v.ref_r, v.wr_r, v.rd_r);
      sb.push_back(mk(g));
      step();
      set_req(1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      check_out(v.name, e);
`ifdef SDRAM_ARB_RR_EN
      if (g == G_WR) last_wr = 1'b1;
      else if (g == G_RD) last_wr = 1'b0;
`endif
      if (g != G_NONE) begin
        fg = (g == G_REF) ? G_WR : (g == G_WR) ? G_RD : G_REF;
        set_end(fg, 1'b1);
        step();
        set_end(fg, 1'b0);
        check_out({v.name, "_foreign"}, mk(g));
        set_end(g, 1'b1);
        step();
        set_end(g, 1'b0);
        check_out({v.name, "_rel"}, mk(G_NONE));
      end
    end

    // ref and wr held together: refresh first, one ARBIT cycle, then write
    set_req(1'b1, 1'b1, 1'b0);
    step();
    check_out("rw_first", mk(G_REF));
    bus.ref_req = 1'b0;
    bus.ref_end = 1'b1;
    step();
    bus.ref_end = 1'b0;
    check_out("rw_gap", mk(G_NONE));
    step();
    check_out("rw_second", mk(G_WR));
    bus.wr_req = 1'b0;
    bus.wr_end = 1'b1;
    step();
    bus.wr_end = 1'b0;
    check_out("rw_rel", mk(G_NONE));

    // read alone: grant next cycle with read address/bank, release after rd_end
    bus.rd_req = 1'b1;
    sb.push_back(mk(G_RD));
    step();
    bus.rd_req = 1'b0;
    e = sb.pop_front();
    check_out("rd_alone", e);
    bus.rd_end = 1'b1;
    step();
    bus.rd_end = 1'b0;
    check_out("rd_alone_rel", mk(G_NONE));

    // write and read held together, end pulsed 4 cycles after each grant
    set_req(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (gnt_now() == G_NONE && n < 10) begin
        step();
        n++;
      end
      chk($sformatf("alt_grant%0d", k), {30'd0, gnt_now()}, {30'd0, rr_exp[k]});
      g = gnt_now();
      repeat (3) step();
      set_end(g, 1'b1);
      step();
      set_end(g, 1'b0);
    end
    set_req(1'b0, 1'b0, 1'b0);
    step();
    step();
    check_out("alt_done", mk(G_NONE));

    // write grant never ended: watchdog releases it and pulses err_tmo once
    bus.wr_req = 1'b1;
    step();
    bus.wr_req = 1'b0;
    check_out("tmo_grant", mk(G_WR));
    n = 1;
    while (bus.wr_en && n < 3000) begin
      chk("tmo_err_early", {31'd0, err_tmo}, 32'd0);
      step();
      n++;
    end
    chk("tmo_len", n - 1, 32'd2048);
    chk("tmo_err_pulse", {31'd0, err_tmo}, 32'd1);
    check_out("tmo_rel", mk(G_NONE));
    step();
    chk("tmo_err_clear", {31'd0, err_tmo}, 32'd0);

    // reset while reading: back to S_INIT immediately
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    check_out("rst_rd_grant", mk(G_RD));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_rd_en",  {29'd0, bus.ref_en, bus.wr_en, bus.rd_en}, 32'd0);
    chk("rst_rd_err", {31'd0, err_tmo}, 32'd0);
    chk("rst_rd_cmd", {28'd0, bus.sdram_cmd}, {28'd0, INIT_CMD});
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    chk("rst_hold_init", {28'd0, bus.sdram_cmd}, {28'd0, INIT_CMD});
    chk("rst_hold_en", {29'd0, bus.ref_en, bus.wr_en, bus.rd_en}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
